// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file parameters and writeback source encoding.
// Imported by the writeback arbiter and the register file so both agree.
package regfile_wb_arbiter_pkg;

    localparam int RF_DATA_W    = 24;
    localparam int RF_ADDR_W    = 4;
    localparam int RF_NUM_REGS  = 1 << RF_ADDR_W;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_arb.sv
// Two-way round-robin arbiter; req[0]/gnt[0] is ALU, req[1]/gnt[1] is MEM.
// Pointer names the favoured source and flips only after a contended grant.
module rr_arb2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_src_e r_ptr;

    // Grant the lone requester, or the favoured one under contention.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (r_ptr == SRC_ALU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Hand priority to the loser after every contended cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= SRC_ALU;
        end else if (&req) begin
            r_ptr <= (r_ptr == SRC_ALU) ? SRC_MEM : SRC_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto one register-file write port.
// Define REGFILE_WB_SCOREBOARD_EN to compile in per-register busy tracking.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_BUS_WIDTH    = RF_DATA_W,
    parameter int REGFILE_ADDR_BITS = RF_ADDR_W,
    parameter int NUM_REGISTERS     = RF_NUM_REGS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alu_valid,
    input  logic [REGFILE_ADDR_BITS-1:0] alu_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    alu_data,
    output logic                         alu_ready,
    input  logic                         mem_valid,
    input  logic [REGFILE_ADDR_BITS-1:0] mem_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    mem_data,
    output logic                         mem_ready,
    output logic                         wr_en,
    output logic [REGFILE_ADDR_BITS-1:0] wr_addr,
    output logic [DATA_BUS_WIDTH-1:0]    wr_data,
    input  logic                         issue_valid,
    input  logic [REGFILE_ADDR_BITS-1:0] issue_addr,
    input  logic [REGFILE_ADDR_BITS-1:0] chk_addr1,
    input  logic [REGFILE_ADDR_BITS-1:0] chk_addr2,
    output logic                         busy1,
    output logic                         busy2
);

    logic [1:0]                   w_req;
    logic [1:0]                   w_gnt;
    logic                         w_xfer;
    logic [REGFILE_ADDR_BITS-1:0] w_sel_addr;
    logic [DATA_BUS_WIDTH-1:0]    w_sel_data;

    logic                         r_wr_en;
    logic [REGFILE_ADDR_BITS-1:0] r_wr_addr;
    logic [DATA_BUS_WIDTH-1:0]    r_wr_data;

    // Requests are masked in reset so neither side sees ready.
    assign w_req = {mem_valid & rst_n, alu_valid & rst_n};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (w_req),
        .gnt   (w_gnt)
    );

    assign alu_ready  = w_gnt[0];
    assign mem_ready  = w_gnt[1];
    assign w_xfer     = |w_gnt;
    assign w_sel_addr = w_gnt[1] ? mem_addr : alu_addr;
    assign w_sel_data = w_gnt[1] ? mem_data : alu_data;

    // One-cycle write stage; writes to x0 are accepted but suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_xfer && (w_sel_addr != '0);
            if (w_xfer) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [NUM_REGISTERS-1:0] r_busy;
    logic [NUM_REGISTERS-1:0] w_set;
    logic [NUM_REGISTERS-1:0] w_clr;

    assign w_set = issue_valid ? (NUM_REGISTERS'(1) << issue_addr) : '0;
    assign w_clr = r_wr_en ? (NUM_REGISTERS'(1) << r_wr_addr) : '0;

    // Issue marks a register pending; its writeback retires it, issue wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_clr) | w_set) & ~NUM_REGISTERS'(1);
        end
    end

    assign busy1 = r_busy[chk_addr1];
    assign busy2 = r_busy[chk_addr2];
`else
    logic w_unused_issue;

    assign w_unused_issue = ^{issue_valid, issue_addr, chk_addr1, chk_addr2};
    assign busy1          = 1'b0;
    assign busy2          = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with an expected-write queue.
// Busy expectations follow REGFILE_WB_SCOREBOARD_EN.
module tb_regfile_wb_arbiter;

`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid;
    logic [3:0]  alu_addr, mem_addr;
    logic [23:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [23:0] wr_data;
    logic        issue_valid;
    logic [3:0]  issue_addr, chk_addr1, chk_addr2;
    logic        busy1, busy2;

    typedef struct packed {
        logic        en;
        logic [3:0]  addr;
        logic [23:0] data;
    } wr_t;

    wr_t  q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic m_ptr = 1'b0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .chk_addr1   (chk_addr1),
        .chk_addr2   (chk_addr2),
        .busy1       (busy1),
        .busy2       (busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Check readies before the edge, queue the expected write, pop after.
    task automatic cycle(input string tag);
        wr_t  e;
        logic ga, gm;
        @(negedge clk);
        ga = alu_valid && (!mem_valid || (m_ptr == 1'b0));
        gm = mem_valid && (!alu_valid || (m_ptr == 1'b1));
        chk({tag, ".alu_ready"}, {31'd0, alu_ready}, {31'd0, ga});
        chk({tag, ".mem_ready"}, {31'd0, mem_ready}, {31'd0, gm});
        e = '0;
        if (ga) begin
            e.en   = (alu_addr != 4'd0);
            e.addr = alu_addr;
            e.data = alu_data;
        end else if (gm) begin
            e.en   = (mem_addr != 4'd0);
            e.addr = mem_addr;
            e.data = mem_data;
        end
        if (alu_valid && mem_valid) m_ptr = ~m_ptr;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({tag, ".wr_en"}, {31'd0, wr_en}, {31'd0, e.en});
        if (e.en) begin
            chk({tag, ".wr_addr"}, {28'd0, wr_addr}, {28'd0, e.addr});
            chk({tag, ".wr_data"}, {8'd0, wr_data}, {8'd0, e.data});
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        alu_valid   = 1'b1;
        mem_valid   = 1'b1;
        alu_addr    = 4'd1;
        alu_data    = 24'h111111;
        mem_addr    = 4'd2;
        mem_data    = 24'h222222;
        issue_valid = 1'b0;
        issue_addr  = 4'd0;
        chk_addr1   = 4'd0;
        chk_addr2   = 4'd0;

        @(negedge clk);
        chk("rst.alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst.mem_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst.wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst.wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("rst.wr_data", {8'd0, wr_data}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cycle("rr0");
        cycle("rr1");
        cycle("rr2");
        cycle("rr3");
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        cycle("idle");

        alu_valid = 1'b1;
        alu_addr  = 4'd3;
        alu_data  = 24'h00ABCD;
        cycle("alu3");
        alu_valid = 1'b0;
        cycle("alu3_after");

        mem_valid = 1'b1;
        mem_addr  = 4'd0;
        mem_data  = 24'hFFFFFF;
        cycle("mem0");
        mem_addr  = 4'd9;
        mem_data  = 24'h0C0FFE;
        cycle("mem9");
        mem_valid = 1'b0;
        cycle("mem9_after");

        issue_valid = 1'b1;
        issue_addr  = 4'd5;
        cycle("iss5");
        issue_valid = 1'b0;
        chk_addr1   = 4'd5;
        chk_addr2   = 4'd6;
        #1;
        chk("iss5.busy1", {31'd0, busy1}, {31'd0, SB});
        chk("iss5.busy2", {31'd0, busy2}, 32'd0);

        alu_valid = 1'b1;
        alu_addr  = 4'd5;
        alu_data  = 24'h555555;
        cycle("w5");
        alu_valid = 1'b0;
        #1;
        chk("w5.busy1_hold", {31'd0, busy1}, {31'd0, SB});
        cycle("w5_end");
        chk("w5_end.busy1", {31'd0, busy1}, 32'd0);

        issue_valid = 1'b1;
        cycle("iss5b");
        issue_valid = 1'b0;
        alu_valid   = 1'b1;
        alu_data    = 24'h5A5A5A;
        cycle("w5b");
        alu_valid   = 1'b0;
        issue_valid = 1'b1;
        cycle("w5b_end");
        issue_valid = 1'b0;
        #1;
        chk("w5b_end.busy1", {31'd0, busy1}, {31'd0, SB});

        alu_valid   = 1'b1;
        alu_addr    = 4'd1;
        alu_data    = 24'h123456;
        mem_valid   = 1'b1;
        mem_addr    = 4'd2;
        mem_data    = 24'h654321;
        issue_valid = 1'b1;
        issue_addr  = 4'd7;
        chk_addr2   = 4'd7;
        cycle("pre");
        mem_valid   = 1'b0;
        issue_valid = 1'b0;
        #1;
        chk("pre.busy2", {31'd0, busy2}, {31'd0, SB});
        chk("pre.alu_ready", {31'd0, alu_ready}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst2.alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst2.wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst2.busy1", {31'd0, busy1}, 32'd0);
        chk("rst2.busy2", {31'd0, busy2}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst2.wr_en_edge", {31'd0, wr_en}, 32'd0);
        chk("rst2.wr_addr", {28'd0, wr_addr}, 32'd0);
        alu_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        m_ptr = 1'b0;
        q.delete();
        cycle("post_idle");

        alu_valid = 1'b1;
        mem_valid = 1'b1;
        cycle("post_rr0");
        cycle("post_rr1");
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        cycle("post_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
